// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one BoothMul datapath among N_REQ requesters, product tagged with requester id.
// Latency: gnt 1 cycle after req is seen in IDLE, mul_start 1 cycle later; requesters hold req until gnt.
module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 63,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   x_in,
  input  logic [N_REQ*W-1:0]   y_in,
  output logic [N_REQ-1:0]     gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*W-1:0]       rsp_z,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [W-1:0]         mul_x,
  output logic [W-1:0]         mul_y,
  input  logic                 mul_valid,
  input  logic [2*W-1:0]       mul_z
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] pick;
  logic           found;
  logic [7:0]     timer;
  logic           mv_prev;
  logic [2*W-1:0] res_z;
  logic           res_err;
  logic [W-1:0]   sel_x;
  logic [W-1:0]   sel_y;
  int             idx;

  // First active requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && ((req >> idx) & N_REQ'(1)) != '0) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == IDW'(k)) begin
        sel_x = x_in[k*W +: W];
        sel_y = y_in[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      timer     <= '0;
      mv_prev   <= 1'b1;
      res_z     <= '0;
      res_err   <= 1'b0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
    end else begin
      mv_prev   <= mul_valid;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= N_REQ'(1) << pick;
            mul_x  <= sel_x;
            mul_y  <= sel_y;
            cur_id <= pick;
            rr_ptr <= (pick == IDW'(N_REQ-1)) ? '0 : pick + 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b1;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Only a fresh rising edge counts; a valid still high from the last op is stale.
          if (mul_valid && !mv_prev) begin
            res_z   <= mul_z;
            res_err <= 1'b0;
            state   <= RESP;
          end else if (timer + 8'd1 == 8'(TIMEOUT)) begin
            res_z   <= '0;
            res_err <= 1'b1;
            state   <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_z     <= res_z;
          rsp_err   <= res_err;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural BoothMul whose valid is sticky between ops.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;
  localparam int N_REQ   = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 63;
  localparam int MLAT    = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*W-1:0] x_in = '0;
  logic [N_REQ*W-1:0] y_in = '0;
  logic [N_REQ-1:0]   gnt;
  logic               rsp_valid;
  logic [1:0]         rsp_id;
  logic [2*W-1:0]     rsp_z;
  logic               rsp_err;
  logic               busy;
  logic               mul_start;
  logic [W-1:0]       mul_x;
  logic [W-1:0]       mul_y;
  logic               mul_valid = 1'b0;
  logic [2*W-1:0]     mul_z = '0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          cyc = 0, n_start = 0, start_cyc = 0, gnt_cyc = 0, rsp_cyc = 0, rise_cyc = 0, gnt_gap = 0;
  int          mcnt = 0;
  bit          dead = 1'b0;
  logic [15:0] mprod = '0;
  int          gnt_q[$];
  logic [18:0] rsp_q[$];

  // Monitor, then the multiplier model: valid drops late after start and rises MLAT cycles after it.
  always @(negedge clk) begin
    cyc++;
    if (mul_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (gnt != '0) begin
      check("gnt_onehot", $countones(gnt), 1);
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) gnt_q.push_back(i);
      gnt_gap = cyc - rsp_cyc;
      gnt_cyc = cyc;
    end
    if (rsp_valid) begin
      rsp_q.push_back({rsp_id, rsp_z, rsp_err});
      rsp_cyc = cyc;
    end
    if (mul_start) begin
      mcnt  = MLAT;
      mprod = $signed({{8{mul_x[7]}}, mul_x}) * $signed({{8{mul_y[7]}}, mul_y});
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 2) mul_valid = 1'b0;
      if (mcnt == 0 && !dead) begin
        mul_valid = 1'b1;
        mul_z     = mprod;
        rise_cyc  = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
    x_in[i*W +: W] = x;
    y_in[i*W +: W] = y;
  endtask

  task automatic wait_gnt(input int n);
    int k = 0;
    while (gnt_q.size() < n && k < 300) begin tick(); k++; end
    check("gnt_arrived", gnt_q.size() >= n, 1);
  endtask

  task automatic wait_start(input int prev);
    int k = 0;
    while (n_start == prev && k < 50) begin tick(); k++; end
    check("start_arrived", n_start != prev, 1);
  endtask

  task automatic expect_rsp(input string tag, input int id, input logic [15:0] z, input logic err);
    int k = 0;
    logic [18:0] r;
    while (rsp_q.size() == 0 && k < 300) begin tick(); k++; end
    check({tag, "_arrived"}, rsp_q.size() != 0, 1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      check({tag, "_id"}, r[18:17], id);
      check({tag, "_z"}, r[16:1], z);
      check({tag, "_err"}, r[0], err);
    end
  endtask

  int          exp_id[5] = '{0, 1, 2, 3, 0};
  logic [15:0] exp_z[5]  = '{16'h000C, 16'hFFEE, 16'hFF9C, 16'h3F01, 16'h000C};
  int          prev;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_start", mul_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mul_x", mul_x, 0);
    rst = 1'b0;

    // 1: 5 * 7
    set_op(0, 8'd5, 8'd7);
    gnt_q.delete(); n_start = 0;
    req = 4'b0001;
    wait_gnt(1);
    check("t1_gnt", gnt, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_mul_x", mul_x, 8'd5);
    req = 4'b0000;
    tick();
    check("t1_gnt_pulse", gnt, 0);
    check("t1_start", mul_start, 1);
    check("t1_start_lat", start_cyc - gnt_cyc, 1);
    expect_rsp("t1", 0, 16'd35, 1'b0);
    check("t1_rsp_lat", rsp_cyc - rise_cyc, 2);
    check("t1_nstart", n_start, 1);

    // 2: -4 * 6 with valid still high from test 1
    set_op(0, 8'hFC, 8'h06);
    gnt_q.delete();
    req = 4'b0001;
    wait_gnt(1);
    req = 4'b0000;
    expect_rsp("t2", 0, 16'hFFE8, 1'b0);

    // 3: all requesting from rr_ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    set_op(0, 8'd3, 8'd4);
    set_op(1, 8'hFE, 8'd9);
    set_op(2, 8'd10, 8'hF6);
    set_op(3, 8'd127, 8'd127);
    gnt_q.delete(); n_start = 0;
    req = 4'b1111;
    wait_gnt(5);
    req = 4'b0000;
    check("t3_b2b_gap", gnt_gap, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_gnt_order", gnt_q[i], exp_id[i]);
      expect_rsp("t3", exp_id[i], exp_z[i], 1'b0);
    end
    check("t3_nstart", n_start, 5);

    // 4: multiplier never answers, then a normal op
    dead = 1'b1;
    set_op(1, 8'd3, 8'd3);
    gnt_q.delete();
    req = 4'b0010;
    wait_gnt(1);
    req = 4'b0000;
    expect_rsp("t4", 1, 16'h0000, 1'b1);
    check("t4_wait_len", rsp_cyc - start_cyc, TIMEOUT + 1);
    check("t4_idle", busy, 0);
    dead = 1'b0;
    set_op(2, 8'd6, 8'hF9);
    req = 4'b0100;
    wait_gnt(2);
    req = 4'b0000;
    expect_rsp("t4b", 2, 16'hFFD6, 1'b0);

    // 5: reset during WAIT drops the op and restarts round-robin at 0
    set_op(1, 8'd2, 8'd2);
    gnt_q.delete();
    req = 4'b0010;
    wait_gnt(1);
    req = 4'b0000;
    prev = n_start;
    wait_start(prev);
    tick(); tick();
    set_op(0, 8'd9, 8'hFD);
    set_op(3, 8'hF9, 8'hF8);
    req = 4'b1001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_start", mul_start, 0);
    check("t5_no_rsp", rsp_q.size(), 0);
    tick();
    check("t5_regrant", gnt, 4'b0001);
    req = 4'b1000;
    expect_rsp("t5a", 0, 16'hFFE5, 1'b0);
    wait_gnt(3);
    req = 4'b0000;
    check("t5_gnt3", gnt_q[2], 3);
    expect_rsp("t5b", 3, 16'h0038, 1'b0);

    // 6: late requester 1 waits for 2's response; extreme operands
    gnt_q.delete();
    set_op(2, 8'h80, 8'h80);
    req = 4'b0100;
    wait_gnt(1);
    prev = n_start;
    wait_start(prev);
    set_op(1, 8'd2, 8'd3);
    req = 4'b0110;
    expect_rsp("t6a", 2, 16'h4000, 1'b0);
    wait_gnt(2);
    req = 4'b0000;
    check("t6_gnt1", gnt_q[1], 1);
    expect_rsp("t6b", 1, 16'd6, 1'b0);
    repeat (3) tick();
    check("t6_idle", busy, 0);
    check("t6_ngnt", gnt_q.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
